// File: rtl/intdiv_otfconv_if.sv
// Handshake bundle for the SD2 on-the-fly converter: digit input side and result output side.
// The neg field exists only when INTDIV_OTF_NEG_EN is defined.
interface intdiv_otfconv_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             digit_valid;
  logic [1:0]       digit;
  logic             digit_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH:0]   res;
  logic             busy;
`ifdef INTDIV_OTF_NEG_EN
  logic             neg;
`endif

  modport master (
    output start, digit_valid, digit, res_ready,
`ifdef INTDIV_OTF_NEG_EN
    output neg,
`endif
    input  digit_ready, res_valid, res, busy
  );

  modport slave (
    input  start, digit_valid, digit, res_ready,
`ifdef INTDIV_OTF_NEG_EN
    input  neg,
`endif
    output digit_ready, res_valid, res, busy
  );
endinterface

// File: rtl/intdiv_otfconv.sv
// Digit-serial SD2 -> two's complement converter using the Q/QM register pair (no carry chain).
// Optional result negation is enabled by defining INTDIV_OTF_NEG_EN.
module intdiv_otfconv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  intdiv_otfconv_if.slave  bus
);
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state, state_n;
  logic [RW-1:0] q, q_n, qm, qm_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ready_reg, ready_n;
  logic          valid_reg, valid_n;
  logic          busy_reg, busy_n;
  logic          d_pos, d_neg;
`ifdef INTDIV_OTF_NEG_EN
  logic          neg_flag, neg_flag_n;
`endif

  // Digit decode; with negation active, +1 and -1 swap roles.
  always_comb begin
    d_pos = (bus.digit == 2'b01) || (bus.digit == 2'b10);
    d_neg = (bus.digit == 2'b11);
`ifdef INTDIV_OTF_NEG_EN
    if (neg_flag) begin
      d_pos = (bus.digit == 2'b11);
      d_neg = (bus.digit == 2'b01) || (bus.digit == 2'b10);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      qm        <= '0;
      cnt       <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef INTDIV_OTF_NEG_EN
      neg_flag  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      q         <= q_n;
      qm        <= qm_n;
      cnt       <= cnt_n;
      ready_reg <= ready_n;
      valid_reg <= valid_n;
      busy_reg  <= busy_n;
`ifdef INTDIV_OTF_NEG_EN
      neg_flag  <= neg_flag_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    qm_n    = qm;
    cnt_n   = cnt;
`ifdef INTDIV_OTF_NEG_EN
    neg_flag_n = neg_flag;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          q_n     = '0;
          qm_n    = '1;
          cnt_n   = '0;
          state_n = CONV;
`ifdef INTDIV_OTF_NEG_EN
          neg_flag_n = bus.neg;
`endif
        end
      end
      CONV: begin
        if (bus.digit_valid) begin
          // Select the shifted source so QM = Q - 1 is preserved without an adder.
          if (d_pos) begin
            q_n  = RW'({q, 1'b1});
            qm_n = RW'({q, 1'b0});
          end else if (d_neg) begin
            q_n  = RW'({qm, 1'b1});
            qm_n = RW'({qm, 1'b0});
          end else begin
            q_n  = RW'({q, 1'b0});
            qm_n = RW'({qm, 1'b1});
          end
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) state_n = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Status flags are registered decodes of the next state.
    ready_n = (state_n == CONV);
    valid_n = (state_n == DONE);
    busy_n  = (state_n == CONV) || (state_n == DONE);
  end

  assign bus.digit_ready = ready_reg;
  assign bus.res_valid   = valid_reg;
  assign bus.busy        = busy_reg;
  assign bus.res         = q;
endmodule

// File: tb/tb_intdiv_otfconv.sv
// Directed and randomized self-checking bench for intdiv_otfconv (WIDTH=8).
// Negation scenarios are compiled in only when INTDIV_OTF_NEG_EN is defined.
module tb_intdiv_otfconv;
  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  intdiv_otfconv_if #(.WIDTH(W)) bus ();

  intdiv_otfconv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full conversion starting and ending on a falling edge; returns res and res_valid at the expected latency.
  task automatic convert(input logic [15:0] digs, input bit negv, output logic [8:0] r, output logic vld);
    bus.start = 1'b1;
`ifdef INTDIV_OTF_NEG_EN
    bus.neg = negv;
`else
    if (negv) $display("note: neg requested without INTDIV_OTF_NEG_EN");
`endif
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit = digs[15-2*i -: 2];
      @(negedge clk);
    end
    bus.digit_valid = 1'b0;
    vld = bus.res_valid;
    r = bus.res;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit = 2'b00;
    bus.res_ready = 1'b0;
`ifdef INTDIV_OTF_NEG_EN
    bus.neg = 1'b0;
`endif
    @(negedge clk);
    total++;
    if ({bus.digit_ready, bus.res_valid, bus.busy, bus.res} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=000", {bus.digit_ready, bus.res_valid, bus.busy, bus.res});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.digit_ready, bus.res_valid, bus.busy} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b exp=000", {bus.digit_ready, bus.res_valid, bus.busy});
    end
  endtask

  task automatic test_basic();
    logic [15:0] digs [3];
    logic [8:0]  exp  [3];
    logic [8:0]  r;
    logic        v;
    digs[0] = 16'h5555; exp[0] = 9'h0FF;
    digs[1] = 16'hFFFF; exp[1] = 9'h101;
    digs[2] = 16'hB000; exp[2] = 9'h040;
    for (int k = 0; k < 3; k++) begin
      convert(digs[k], 1'b0, r, v);
      total++;
      if (v !== 1'b1) begin
        bad++;
        $display("FAIL basic_valid[%0d] got=%b exp=1", k, v);
      end
      total++;
      if (r !== exp[k]) begin
        bad++;
        $display("FAIL basic_res[%0d] got=%h exp=%h", k, r, exp[k]);
      end
      total++;
      if ({bus.res_valid, bus.busy} !== 2'b00) begin
        bad++;
        $display("FAIL basic_exit[%0d] got=%b exp=00", k, {bus.res_valid, bus.busy});
      end
    end
  endtask

  // Digit string +1,-1,0,+1,0,-1,+1,+1 = 79, fed with random gaps and spurious starts.
  task automatic test_stall();
    logic [15:0] digs;
    int i;
    int guard;
    digs = 16'h7235;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if ({bus.digit_ready, bus.busy} !== 2'b11) begin
      bad++;
      $display("FAIL conv_entry got=%b exp=11", {bus.digit_ready, bus.busy});
    end
    i = 0;
    guard = 0;
    while (i < 8 && guard < 200) begin
      guard++;
      if ($urandom_range(0, 2) == 0) begin
        bus.digit_valid = 1'b0;
        bus.digit = 2'($urandom_range(0, 3));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if ({bus.digit_ready, bus.res_valid, bus.busy} !== 3'b101) begin
          bad++;
          $display("FAIL stall_gap got=%b exp=101", {bus.digit_ready, bus.res_valid, bus.busy});
        end
      end else begin
        bus.digit_valid = 1'b1;
        bus.digit = digs[15-2*i -: 2];
        @(negedge clk);
        i++;
      end
    end
    bus.digit_valid = 1'b0;
    total++;
    if (i != 8) begin
      bad++;
      $display("FAIL stall_budget got=%0d exp=8", i);
    end
    for (int h = 0; h < 5; h++) begin
      bus.start = 1'b1;
      bus.digit_valid = 1'b1;
      @(negedge clk);
      total++;
      if ({bus.res_valid, bus.busy, bus.digit_ready, bus.res} !== {3'b110, 9'h04F}) begin
        bad++;
        $display("FAIL done_hold[%0d] got=%h exp=%h", h, {bus.res_valid, bus.busy, bus.digit_ready, bus.res}, {3'b110, 9'h04F});
      end
    end
    bus.start = 1'b0;
    bus.digit_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    total++;
    if ({bus.res_valid, bus.busy, bus.res} !== {2'b00, 9'h04F}) begin
      bad++;
      $display("FAIL done_exit got=%h exp=%h", {bus.res_valid, bus.busy, bus.res}, {2'b00, 9'h04F});
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit = 2'b01;
      @(negedge clk);
    end
    bus.digit_valid = 1'b0;
    // start coinciding with the DONE exit must be ignored
    bus.res_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    total++;
    if ({bus.busy, bus.res_valid, bus.digit_ready} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_exit_start got=%b exp=000", {bus.busy, bus.res_valid, bus.digit_ready});
    end
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if ({bus.busy, bus.digit_ready} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_idle_start got=%b exp=11", {bus.busy, bus.digit_ready});
    end
    for (int i = 0; i < 8; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit = 2'b11;
      @(negedge clk);
    end
    bus.digit_valid = 1'b0;
    total++;
    if ({bus.res_valid, bus.res} !== {1'b1, 9'h101}) begin
      bad++;
      $display("FAIL b2b_res got=%h exp=%h", {bus.res_valid, bus.res}, {1'b1, 9'h101});
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [8:0] r;
    logic       v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit = 2'b01;
      @(negedge clk);
    end
    bus.digit_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.digit_ready, bus.res_valid, bus.busy, bus.res} !== 12'h000) begin
      bad++;
      $display("FAIL async_reset got=%h exp=000", {bus.digit_ready, bus.res_valid, bus.busy, bus.res});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    convert(16'h0001, 1'b0, r, v);
    total++;
    if ({v, r} !== {1'b1, 9'h001}) begin
      bad++;
      $display("FAIL post_reset_res got=%h exp=%h", {v, r}, {1'b1, 9'h001});
    end
  endtask

`ifdef INTDIV_OTF_NEG_EN
  task automatic test_neg();
    logic [8:0] r;
    logic       v;
    convert(16'h0001, 1'b1, r, v);
    total++;
    if ({v, r} !== {1'b1, 9'h1FF}) begin
      bad++;
      $display("FAIL neg_one got=%h exp=%h", {v, r}, {1'b1, 9'h1FF});
    end
    convert(16'h0001, 1'b0, r, v);
    total++;
    if ({v, r} !== {1'b1, 9'h001}) begin
      bad++;
      $display("FAIL pos_one got=%h exp=%h", {v, r}, {1'b1, 9'h001});
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] da, db;
    logic [8:0]  ra, rb, exp;
    logic        va, vb;
    int          refv;
    int          sel;
    bit          negv;
    for (int n = 0; n < 1000; n++) begin
      refv = 0;
      da = '0;
      db = '0;
      for (int i = 0; i < 8; i++) begin
        sel = $urandom_range(0, 2);
        if (sel == 1) begin
          da[15-2*i -: 2] = 2'b01;
          db[15-2*i -: 2] = 2'b10;
          refv += (1 << (7 - i));
        end else if (sel == 2) begin
          da[15-2*i -: 2] = 2'b11;
          db[15-2*i -: 2] = 2'b11;
          refv -= (1 << (7 - i));
        end
      end
`ifdef INTDIV_OTF_NEG_EN
      negv = 1'($urandom_range(0, 1));
`else
      negv = 1'b0;
`endif
      exp = negv ? 9'(-refv) : 9'(refv);
      convert(da, negv, ra, va);
      convert(db, negv, rb, vb);
      total++;
      if ({va, vb, ra} !== {2'b11, exp}) begin
        bad++;
        $display("FAIL rand_res[%0d] digs=%h neg=%0d got=%b_%h exp=11_%h", n, da, negv, {va, vb}, ra, exp);
      end
      total++;
      if (rb !== ra) begin
        bad++;
        $display("FAIL rand_enc[%0d] digs=%h got=%h exp=%h", n, db, rb, ra);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_async_reset();
`ifdef INTDIV_OTF_NEG_EN
    test_neg();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
